countdown_timer: RTL and testbench



---
 rtl/countdown_timer_if.sv | 25 ++
 rtl/countdown_timer.sv | 199 +++++++++++++++++++
 tb/tb_countdown_timer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Front-panel bundle for countdown_timer: run/load controls, M:SS start value,
// the five seven-segment digit outputs and the status flags.
interface countdown_timer_if;
    logic       enable;
    logic       load;
    logic [3:0] load_min;
    logic [5:0] load_sec;
    logic [6:0] HEXfour;
    logic [6:0] HEXthree;
    logic [6:0] HEXtwo;
    logic [6:0] HEXone;
    logic [6:0] HEXzero;
    logic       running;
    logic       done;

    modport master (
        output enable, load, load_min, load_sec,
        input  HEXfour, HEXthree, HEXtwo, HEXone, HEXzero, running, done
    );

    modport slave (
        input  enable, load, load_min, load_sec,
        output HEXfour, HEXthree, HEXtwo, HEXone, HEXzero, running, done
    );
endinterface

// File: rtl/countdown_timer.sv
// M:SS.hh count-down timer: BCD digit registers decremented once per 1/100 s
// prescaler period, shown on five active-low seven-segment displays.
module countdown_timer #(
    parameter int TICK_DIV = 500000
) (
    input  logic               clock,
    input  logic               resetn,
    countdown_timer_if.slave   tmr
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    m_q, m_d;
    logic [2:0]    s1_q, s1_d;
    logic [3:0]    s0_q, s0_d;
    logic [3:0]    c1_q, c1_d;
    logic [3:0]    c0_q, c0_d;

    logic [3:0]    dec_m_s, dec_s0_s, dec_c1_s, dec_c0_s;
    logic [2:0]    dec_s1_s;
    logic          count_zero_s, dec_zero_s;
    logic [3:0]    ld_min_s;
    logic [6:0]    ld_sec_bcd_s;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Clamps seconds to 59 and splits into {tens[2:0], ones[3:0]}.
    function automatic logic [6:0] sec_to_bcd(input logic [5:0] sec);
        logic [2:0] tens;
        logic [3:0] ones;
        if (sec > 6'd59) begin
            tens = 3'd5; ones = 4'd9;
        end else if (sec >= 6'd50) begin
            tens = 3'd5; ones = 4'(sec - 6'd50);
        end else if (sec >= 6'd40) begin
            tens = 3'd4; ones = 4'(sec - 6'd40);
        end else if (sec >= 6'd30) begin
            tens = 3'd3; ones = 4'(sec - 6'd30);
        end else if (sec >= 6'd20) begin
            tens = 3'd2; ones = 4'(sec - 6'd20);
        end else if (sec >= 6'd10) begin
            tens = 3'd1; ones = 4'(sec - 6'd10);
        end else begin
            tens = 3'd0; ones = 4'(sec);
        end
        return {tens, ones};
    endfunction

    // Load-value conditioning and the one-hundredth borrow chain.
    always_comb begin
        ld_min_s     = (tmr.load_min > 4'd9) ? 4'd9 : tmr.load_min;
        ld_sec_bcd_s = sec_to_bcd(tmr.load_sec);

        dec_c0_s = (c0_q == 4'd0) ? 4'd9 : c0_q - 4'd1;
        dec_c1_s = c1_q;
        dec_s0_s = s0_q;
        dec_s1_s = s1_q;
        dec_m_s  = m_q;
        if (c0_q == 4'd0) begin
            dec_c1_s = (c1_q == 4'd0) ? 4'd9 : c1_q - 4'd1;
            if (c1_q == 4'd0) begin
                dec_s0_s = (s0_q == 4'd0) ? 4'd9 : s0_q - 4'd1;
                if (s0_q == 4'd0) begin
                    dec_s1_s = (s1_q == 3'd0) ? 3'd5 : s1_q - 3'd1;
                    if (s1_q == 3'd0) begin
                        dec_m_s = m_q - 4'd1;
                    end else begin
                        dec_m_s = m_q;
                    end
                end else begin
                    dec_s1_s = s1_q;
                end
            end else begin
                dec_s0_s = s0_q;
            end
        end else begin
            dec_c1_s = c1_q;
        end

        count_zero_s = (m_q == 4'd0) && (s1_q == 3'd0) && (s0_q == 4'd0)
                    && (c1_q == 4'd0) && (c0_q == 4'd0);
        dec_zero_s   = (dec_m_s == 4'd0) && (dec_s1_s == 3'd0) && (dec_s0_s == 4'd0)
                    && (dec_c1_s == 4'd0) && (dec_c0_s == 4'd0);
    end

    // Next-state: load overrides everything, then the run/pause/expire FSM.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        m_d     = m_q;
        s1_d    = s1_q;
        s0_d    = s0_q;
        c1_d    = c1_q;
        c0_d    = c0_q;
        if (tmr.load) begin
            m_d     = ld_min_s;
            s1_d    = ld_sec_bcd_s[6:4];
            s0_d    = ld_sec_bcd_s[3:0];
            c1_d    = 4'd0;
            c0_d    = 4'd0;
            presc_d = {PW{1'b0}};
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tmr.enable && !count_zero_s) begin
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (!tmr.enable) begin
                        state_d = PAUSE;
                    end else if (presc_q == TICK_LAST) begin
                        presc_d = {PW{1'b0}};
                        m_d     = dec_m_s;
                        s1_d    = dec_s1_s;
                        s0_d    = dec_s0_s;
                        c1_d    = dec_c1_s;
                        c0_d    = dec_c0_s;
                        if (dec_zero_s) begin
                            state_d = EXPIRED;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
                    end
                end
                PAUSE: begin
                    if (tmr.enable) begin
                        state_d = RUN;
                    end else begin
                        state_d = PAUSE;
                    end
                end
                EXPIRED: state_d = EXPIRED;
                default: state_d = IDLE;
            endcase
        end
    end

    // State, prescaler and digit registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            presc_q <= {PW{1'b0}};
            m_q     <= 4'd0;
            s1_q    <= 3'd0;
            s0_q    <= 4'd0;
            c1_q    <= 4'd0;
            c0_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            m_q     <= m_d;
            s1_q    <= s1_d;
            s0_q    <= s0_d;
            c1_q    <= c1_d;
            c0_q    <= c0_d;
        end
    end

    assign tmr.HEXfour  = seg7(m_q);
    assign tmr.HEXthree = seg7({1'b0, s1_q});
    assign tmr.HEXtwo   = seg7(s0_q);
    assign tmr.HEXone   = seg7(c1_q);
    assign tmr.HEXzero  = seg7(c0_q);
    assign tmr.running  = (state_q == RUN);
    assign tmr.done     = (state_q == EXPIRED);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer (TICK_DIV=4): stimulus queues expected
// display/status snapshots, a negedge monitor pops and compares them.
module tb_countdown_timer;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    countdown_timer_if tmr ();

    countdown_timer #(.TICK_DIV(4)) dut (
        .clock  (clock),
        .resetn (resetn),
        .tmr    (tmr)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [36:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic expect_disp(input string name, input int m, input int s1, input int s0,
                               input int c1, input int c0, input logic run, input logic dn);
        exp_t e;
        e.name = name;
        e.val  = {seg_of(m), seg_of(s1), seg_of(s0), seg_of(c1), seg_of(c0), run, dn};
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitor: compares the DUT outputs against each queued snapshot.
    always @(negedge clock) begin
        logic [36:0] got;
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            got = {tmr.HEXfour, tmr.HEXthree, tmr.HEXtwo, tmr.HEXone, tmr.HEXzero,
                   tmr.running, tmr.done};
            n_checks++;
            if (got !== mon_e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h (hex4..hex0,running,done)",
                         mon_e.name, got, mon_e.val);
            end
        end
    end

    initial begin
        tmr.enable   = 1'b0;
        tmr.load     = 1'b0;
        tmr.load_min = 4'd0;
        tmr.load_sec = 6'd0;
        cyc(2);
        expect_disp("reset", 0, 0, 0, 0, 0, 1'b0, 1'b0);

        // enable with count 0 must not start or expire
        resetn = 1'b1;
        tmr.enable = 1'b1;
        cyc(3);
        expect_disp("en_zero", 0, 0, 0, 0, 0, 1'b0, 1'b0);

        // load 0:01, run to expiry
        tmr.enable = 1'b0; tmr.load = 1'b1; tmr.load_min = 4'd0; tmr.load_sec = 6'd1;
        cyc(1);
        tmr.load = 1'b0;
        expect_disp("load_001", 0, 0, 1, 0, 0, 1'b0, 1'b0);
        tmr.enable = 1'b1;
        cyc(1);
        expect_disp("run_entry", 0, 0, 1, 0, 0, 1'b1, 1'b0);
        cyc(3);
        expect_disp("pre_tick", 0, 0, 1, 0, 0, 1'b1, 1'b0);
        cyc(1);
        expect_disp("first_tick", 0, 0, 0, 9, 9, 1'b1, 1'b0);
        cyc(395);
        expect_disp("tick99", 0, 0, 0, 0, 1, 1'b1, 1'b0);
        cyc(1);
        expect_disp("expire", 0, 0, 0, 0, 0, 1'b0, 1'b1);
        tmr.enable = 1'b0;
        cyc(3);
        tmr.enable = 1'b1;
        cyc(5);
        expect_disp("expired_hold", 0, 0, 0, 0, 0, 1'b0, 1'b1);

        resetn = 1'b0;
        cyc(1);
        expect_disp("rst_expired", 0, 0, 0, 0, 0, 1'b0, 1'b0);
        resetn = 1'b1;

        // load 1:00, one tick exercises the full borrow chain
        tmr.enable = 1'b0; tmr.load = 1'b1; tmr.load_min = 4'd1; tmr.load_sec = 6'd0;
        cyc(1);
        tmr.load = 1'b0;
        expect_disp("load_100", 1, 0, 0, 0, 0, 1'b0, 1'b0);
        tmr.enable = 1'b1;
        cyc(5);
        expect_disp("borrow_chain", 0, 5, 9, 9, 9, 1'b1, 1'b0);

        // pause two cycles into a tick period, resume keeps the phase
        cyc(2);
        tmr.enable = 1'b0;
        cyc(1);
        expect_disp("paused", 0, 5, 9, 9, 9, 1'b0, 1'b0);
        cyc(9);
        tmr.enable = 1'b1;
        cyc(1);
        expect_disp("resume", 0, 5, 9, 9, 9, 1'b1, 1'b0);
        cyc(1);
        expect_disp("resume_pre", 0, 5, 9, 9, 9, 1'b1, 1'b0);
        cyc(1);
        expect_disp("resume_tick", 0, 5, 9, 9, 8, 1'b1, 1'b0);

        // load on the tick edge wins over the decrement
        cyc(3);
        tmr.load = 1'b1; tmr.load_min = 4'd2; tmr.load_sec = 6'd30;
        cyc(1);
        tmr.load = 1'b0;
        expect_disp("load_wins", 2, 3, 0, 0, 0, 1'b0, 1'b0);
        cyc(1);
        expect_disp("rerun", 2, 3, 0, 0, 0, 1'b1, 1'b0);
        cyc(2);
        resetn = 1'b0;
        cyc(1);
        expect_disp("rst_run", 0, 0, 0, 0, 0, 1'b0, 1'b0);
        resetn = 1'b1;
        tmr.enable = 1'b0;

        // clamping and seconds BCD conversion
        tmr.load = 1'b1; tmr.load_min = 4'd12; tmr.load_sec = 6'd63;
        cyc(1);
        expect_disp("clamp", 9, 5, 9, 0, 0, 1'b0, 1'b0);
        tmr.load_min = 4'd3; tmr.load_sec = 6'd45;
        cyc(1);
        expect_disp("load_345", 3, 4, 5, 0, 0, 1'b0, 1'b0);
        tmr.load_min = 4'd0; tmr.load_sec = 6'd10;
        cyc(1);
        tmr.load = 1'b0;
        tmr.enable = 1'b1;
        cyc(5);
        expect_disp("s1_borrow", 0, 0, 9, 9, 9, 1'b1, 1'b0);

        cyc(2);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
